// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant of the shared bus, one-cycle broadcast
// of the winning request, then a watchdog-bounded wait for the crossbar completion.
package bus_arbiter_pkg;
    // Message field widths match the default NUM_CPUS=4 / XLEN=6 configuration
    localparam int BA_SRC_W  = 3;
    localparam int BA_ADDR_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GETS = 2'd1,
        GETM = 2'd2,
        PUTM = 2'd3
    } bus_tx_t;

    typedef struct packed {
        logic                 valid;
        logic [BA_SRC_W-1:0]  source;
        logic [BA_ADDR_W-1:0] addr;
        bus_tx_t              bus_tx;
    } bus_msg_t;

    typedef struct packed {
        logic                 valid;
        logic                 memory_flag;
        logic [BA_SRC_W-1:0]  destination;
        logic [BA_ADDR_W-1:0] addr;
    } xbar_msg_t;
endpackage

module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_CPUS = 4,
    parameter int XLEN     = 6,
    parameter int TIMEOUT  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CPUS-1:0]            req_valid,
    input  logic [NUM_CPUS-1:0][XLEN-1:0]  req_addr,
    input  bus_tx_t [NUM_CPUS-1:0]         req_tx,
    input  xbar_msg_t                      xbar_in,
    output logic [NUM_CPUS-1:0]            grant,
    output bus_msg_t                       bus_out,
    output logic                           busy,
    output logic                           timeout_err
);
    localparam int         IDX_W    = (NUM_CPUS > 1) ? $clog2(NUM_CPUS) : 1;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_ARB, S_BCAST, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    bus_tx_t               tx_q, tx_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [NUM_CPUS-1:0]   grant_q, grant_d;
    bus_msg_t              bus_out_q, bus_out_d;
    logic                  timeout_err_q, timeout_err_d;

    logic [NUM_CPUS-1:0]   eligible;
    logic                  found;
    logic [IDX_W-1:0]      sel_idx;
    logic [BA_SRC_W-1:0]   src_ext;
    logic                  addr_hit;
    logic                  complete;

    for (genvar gi = 0; gi < NUM_CPUS; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi] && (req_tx[gi] != IDLE);
    end

    // Round-robin scan starting just after the last owner
    always_comb begin
        int cand;
        cand    = 0;
        found   = 1'b0;
        sel_idx = '0;
        for (int k = 1; k <= NUM_CPUS; k++) begin
            cand = (int'(ptr_q) + k) % NUM_CPUS;
            if (!found && eligible[IDX_W'(cand)]) begin
                found   = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    assign src_ext  = BA_SRC_W'(idx_q);
    assign addr_hit = xbar_in.valid && (xbar_in.addr == BA_ADDR_W'(addr_q));
    // Writebacks finish at memory; reads finish when data reaches the requester
    assign complete = (tx_q == PUTM) ? (addr_hit && xbar_in.memory_flag)
                                     : (addr_hit && !xbar_in.memory_flag &&
                                        (xbar_in.destination == src_ext));

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        addr_d        = addr_q;
        tx_d          = tx_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        bus_out_d     = bus_out_q;
        timeout_err_d = 1'b0;
        case (state_q)
            S_ARB: begin
                grant_d = '0;
                if (found) begin
                    idx_d            = sel_idx;
                    addr_d           = req_addr[sel_idx];
                    tx_d             = req_tx[sel_idx];
                    grant_d[sel_idx] = 1'b1;
                    bus_out_d        = '{valid:  1'b1,
                                         source: BA_SRC_W'(sel_idx),
                                         addr:   BA_ADDR_W'(req_addr[sel_idx]),
                                         bus_tx: req_tx[sel_idx]};
                    state_d          = S_BCAST;
                end
            end
            S_BCAST: begin
                bus_out_d.valid  = 1'b0;
                bus_out_d.bus_tx = IDLE;
                cnt_d            = '0;
                state_d          = S_WAIT;
            end
            S_WAIT: begin
                if (complete || (cnt_q == CNT_LAST)) begin
                    ptr_d         = idx_q;
                    grant_d       = '0;
                    timeout_err_d = !complete;
                    state_d       = S_ARB;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_ARB;
            ptr_q         <= IDX_W'(NUM_CPUS - 1);
            idx_q         <= '0;
            addr_q        <= '0;
            tx_q          <= IDLE;
            cnt_q         <= '0;
            grant_q       <= '0;
            bus_out_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            addr_q        <= addr_d;
            tx_q          <= tx_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            bus_out_q     <= bus_out_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign bus_out     = bus_out_q;
    assign busy        = (state_q != S_ARB);
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected broadcasts are queued by the stimulus
// and popped by a negedge monitor whenever bus_out.valid is seen.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int XL = 6;
    localparam int TO = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             req_valid;
    logic [N-1:0][XL-1:0]     req_addr;
    bus_tx_t [N-1:0]          req_tx;
    xbar_msg_t                xbar_in;
    logic [N-1:0]             grant;
    bus_msg_t                 bus_out;
    logic                     busy;
    logic                     timeout_err;

    always #5 clk = ~clk;

    bus_arbiter #(.NUM_CPUS(N), .XLEN(XL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_tx(req_tx), .xbar_in(xbar_in), .grant(grant), .bus_out(bus_out),
        .busy(busy), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [2:0] src;
        logic [5:0] addr;
        bus_tx_t    tx;
        logic [3:0] grant;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec     = 0;
    int   n_bad     = 0;
    int   te_pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic push_exp(input int src, input logic [5:0] a, input bus_tx_t tx);
        exp_t e;
        e.src   = 3'(src);
        e.addr  = a;
        e.tx    = tx;
        e.grant = 4'(1 << src);
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst && timeout_err) te_pulses++;
        if (bus_out.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_bcast: got src %0d addr 0x%0h required no broadcast",
                         bus_out.source, bus_out.addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("bcast_src",   32'(bus_out.source), 32'(mon_e.src));
                check("bcast_addr",  32'(bus_out.addr),   32'(mon_e.addr));
                check("bcast_tx",    32'(bus_out.bus_tx), 32'(mon_e.tx));
                check("bcast_grant", 32'(grant),          32'(mon_e.grant));
            end
        end
    end

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        while (cycles < 20) begin
            tick();
            cycles++;
            if (grant != '0) break;
        end
        if (grant == '0) begin
            n_vec++;
            n_bad++;
            $display("FAIL grant_wait: got no grant required one within 20 cycles");
        end
    endtask

    task automatic respond(input logic mf, input logic [2:0] dst, input logic [5:0] a);
        xbar_in = '{valid: 1'b1, memory_flag: mf, destination: dst, addr: a};
        tick();
        xbar_in = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before 100000 time units");
        $fatal(1);
    end

    initial begin
        int cyc;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        for (int i = 0; i < N; i++) req_tx[i] = IDLE;
        xbar_in   = '0;
        repeat (3) tick();
        check("reset_grant",   32'(grant),       32'h0);
        check("reset_busy",    32'(busy),        32'h0);
        check("reset_terr",    32'(timeout_err), 32'h0);
        check("reset_bus_out", 32'(bus_out),     32'h0);
        rst = 1'b0;

        // IDLE transaction with valid asserted is not eligible
        req_valid = 4'b0001;
        repeat (5) tick();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_busy",  32'(busy),  32'h0);

        // All four CPUs issue GETS: served CPU0..CPU3 in order
        for (int i = 0; i < N; i++) begin
            req_tx[i]   = GETS;
            req_addr[i] = 6'h10 + 6'(i);
            push_exp(i, 6'h10 + 6'(i), GETS);
        end
        req_valid = 4'hF;
        for (int i = 0; i < N; i++) begin
            wait_grant(cyc);
            check("rr_latency", 32'(cyc), 32'd1);
            check("rr_busy", 32'(busy), 32'h1);
            tick();
            respond(1'b0, 3'(i), 6'h10 + 6'(i));
            check("rr_release", 32'(grant), 32'h0);
        end
        req_valid = '0;

        // CPU2 GETM; request withdrawn and altered after latching
        req_tx[2]   = GETM;
        req_addr[2] = 6'h2A;
        req_valid   = 4'b0100;
        push_exp(2, 6'h2A, GETM);
        wait_grant(cyc);
        req_valid   = '0;
        req_addr[2] = 6'h00;
        req_tx[2]   = IDLE;
        tick();
        check("getm_hold", 32'(grant), 32'h4);
        respond(1'b0, 3'd2, 6'h2A);
        check("getm_release", 32'(grant), 32'h0);

        // CPU1 PUTM: only a memory-flagged response completes it
        req_tx[1]   = PUTM;
        req_addr[1] = 6'h15;
        req_valid   = 4'b0010;
        push_exp(1, 6'h15, PUTM);
        wait_grant(cyc);
        req_valid = '0;
        tick();
        respond(1'b0, 3'd1, 6'h15);
        check("putm_ignore_mf0", 32'(grant), 32'h2);
        respond(1'b1, 3'd0, 6'h15);
        check("putm_release", 32'(grant), 32'h0);

        // Unanswered GETS from CPU2 times out, then CPU0 is served
        req_tx[0]   = GETS;
        req_addr[0] = 6'h05;
        req_tx[2]   = GETS;
        req_addr[2] = 6'h2C;
        req_valid   = 4'b0101;
        push_exp(2, 6'h2C, GETS);
        push_exp(0, 6'h05, GETS);
        wait_grant(cyc);
        req_valid = 4'b0001;
        cyc = 0;
        while (timeout_err !== 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("timeout_cycles", 32'(cyc), 32'(TO + 1));
        check("timeout_grant", 32'(grant), 32'h0);
        tick();
        check("timeout_pulse_end", 32'(timeout_err), 32'h0);
        check("after_timeout_grant", 32'(grant), 32'h1);

        // Reset in S_WAIT aborts; CPU0 is first afterwards
        tick();
        rst         = 1'b1;
        req_tx[1]   = GETS;
        req_addr[1] = 6'h21;
        req_valid   = 4'b0011;
        tick();
        check("rst_grant",   32'(grant),       32'h0);
        check("rst_busy",    32'(busy),        32'h0);
        check("rst_terr",    32'(timeout_err), 32'h0);
        check("rst_bus_out", 32'(bus_out),     32'h0);
        rst = 1'b0;
        push_exp(0, 6'h05, GETS);
        push_exp(1, 6'h21, GETS);
        wait_grant(cyc);
        check("post_rst_latency", 32'(cyc), 32'd1);
        tick();
        respond(1'b0, 3'd0, 6'h05);
        check("post_rst_release0", 32'(grant), 32'h0);
        wait_grant(cyc);
        req_valid = '0;
        tick();
        respond(1'b0, 3'd1, 6'h21);
        check("post_rst_release1", 32'(grant), 32'h0);

        repeat (3) tick();
        check("timeout_pulses",   32'(te_pulses),    32'd1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001: Parameter NUM_CPUS, default 4, number of requesting cache controllers.
REQ-002: Parameter XLEN, default 6, address width.
REQ-003: Parameter TIMEOUT, default 64, maximum S_WAIT cycles before abort; fits an 8-bit counter.
REQ-004: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005: rst  input  1  reset, synchronous, active-high.
REQ-006: req_valid  input  NUM_CPUS  per-CPU bus request.
REQ-007: req_addr  input  NUM_CPUS x XLEN  per-CPU request address.
REQ-008: req_tx  input  NUM_CPUS x bus_tx_t  per-CPU transaction (GETS/GETM/PUTM/IDLE).
REQ-009: xbar_in  input  xbar_msg_t  crossbar traffic, snooped for completion.
REQ-010: grant  output  NUM_CPUS  one-hot bus ownership, registered.
REQ-011: bus_out  output  bus_msg_t  broadcast snoop message, registered.
REQ-012: busy  output  1  high whenever state is not S_ARB.
REQ-013: timeout_err  output  1  one-cycle pulse on watchdog abort.

Function
REQ-014: The block SHALL implement FSM states S_ARB, S_BCAST and S_WAIT.
REQ-015: CPU i SHALL be eligible iff req_valid[i]=1 and req_tx[i]!=IDLE.
REQ-016: In S_ARB with at least one eligible CPU, the block SHALL select the first eligible index scanning ptr+1, ptr+2, ... modulo NUM_CPUS, latch index, addr and tx, and enter S_BCAST.
REQ-017: In S_ARB with no eligible CPU, the block SHALL remain in S_ARB with grant=0.
REQ-018: In S_BCAST, for exactly one cycle, bus_out.valid SHALL be 1, with source=latched index zero-extended to $clog2(NUM_CPUS)+1 bits, addr=latched addr and bus_tx=latched tx; the next state SHALL be S_WAIT.
REQ-019: grant[latched index] SHALL be high from S_BCAST through the last S_WAIT cycle; all other grant bits SHALL be 0.
REQ-020: In S_WAIT, bus_out.valid SHALL be 0 and bus_out.bus_tx SHALL be IDLE.
REQ-021: Completion for latched GETS/GETM SHALL be xbar_in.valid=1, memory_flag=0, destination=latched source and addr=latched addr.
REQ-022: Completion for latched PUTM SHALL be xbar_in.valid=1, memory_flag=1 and addr=latched addr.
REQ-023: xbar_in SHALL be ignored in S_ARB and S_BCAST.
REQ-024: On completion, the block SHALL set ptr to the latched index, clear grant on the next cycle and return to S_ARB.
REQ-025: The wait counter SHALL clear on S_WAIT entry and increment each S_WAIT cycle.
REQ-026: If the counter reaches TIMEOUT-1 without completion, the block SHALL pulse timeout_err, update ptr as on completion and return to S_ARB.
REQ-027: If completion and timeout occur in the same cycle, completion SHALL win and no timeout_err SHALL be raised.
REQ-028: A request deasserted before selection SHALL be dropped without effect; changes to req_* after latching SHALL be ignored.
REQ-029: Latency SHALL be: eligible in S_ARB at cycle n gives bus_out.valid and grant at n+1; completion at cycle m gives grant=0 at m+1; the earliest next broadcast is at m+2.

Reset
REQ-030: While rst=1, the block SHALL set state=S_ARB, ptr=NUM_CPUS-1 (CPU0 first), counter=0, grant=0, busy=0, timeout_err=0, and bus_out={valid 0, source 0, addr 0, bus_tx IDLE}.
REQ-031: Reset asserted mid-transaction SHALL abort the transaction without a completion or timeout_err.

Verification
REQ-032: After reset, req_valid=4'b1111, all GETS -> grants issued in order CPU0, CPU1, CPU2, CPU3, each completed by a matching xbar_in response.
REQ-033: CPU2 GETM addr 6'h2A alone -> next cycle bus_out={1, 3'd2, 6'h2A, GETM} and grant=4'b0100; xbar_in dest=2, addr=6'h2A, memory_flag=0 -> grant=0 on the following cycle.
REQ-034: CPU1 PUTM addr 6'h15; xbar_in memory_flag=0 at 6'h15, then memory_flag=1 at 6'h15 -> only the second response completes the transaction.
REQ-035: GETS with no response -> timeout_err pulses once after TIMEOUT S_WAIT cycles; the next eligible CPU is then granted.
REQ-036: rst in S_WAIT -> all outputs at reset values the next cycle; a pending CPU0 request is granted first afterward.
REQ-037: req_tx=IDLE with req_valid=1 -> no grant and no broadcast.
